// File: rtl/counter_ii.sv
// rtl/counter_ii.sv - two-digit BCD up-counter with debounced pause button and muxed 7-seg driver
module counter_ii #(
  parameter int TICK_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SCAN_CYCLES     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  output logic [7:0] digtal_sw,
  output logic [7:0] seg_led,
  output logic [7:0] count_out
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_CYCLES - 1);

  logic          stop_s1;
  logic          stop_s2;
  logic          db_level;
  logic          db_prev;
  logic [DW-1:0] db_cnt;
  logic          run;
  logic [TW-1:0] pre;
  logic [SW-1:0] scan_cnt;
  logic          scan_idx;
  logic [3:0]    ones;
  logic [3:0]    tens;
  logic          tick;
  logic          db_rise;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // tick uses the pre-edge run state, so a toggle landing on a tick still increments
  assign tick      = run && (pre == TICK_MAX);
  assign db_rise   = db_level && !db_prev;
  assign count_out = {tens, ones};

  always_ff @(posedge clk) begin
    if (!rst) begin
      stop_s1   <= 1'b0;
      stop_s2   <= 1'b0;
      db_level  <= 1'b0;
      db_prev   <= 1'b0;
      db_cnt    <= '0;
      run       <= 1'b1;
      pre       <= '0;
      scan_cnt  <= '0;
      scan_idx  <= 1'b0;
      ones      <= 4'd0;
      tens      <= 4'd0;
      digtal_sw <= 8'hFE;
      seg_led   <= 8'hC0;
    end else begin
      stop_s1 <= stop;
      stop_s2 <= stop_s1;

      // accept a new level only after an unbroken run of mismatching samples
      if (stop_s2 != db_level) begin
        if (db_cnt == DB_MAX) begin
          db_level <= stop_s2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      db_prev <= db_level;

      if (db_rise)
        run <= !run;

      if (run)
        pre <= tick ? '0 : pre + 1'b1;

      if (tick) begin
        if (ones == 4'd9) begin
          ones <= 4'd0;
          tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
          ones <= ones + 4'd1;
        end
      end

      if (scan_cnt == SCAN_MAX) begin
        scan_cnt <= '0;
        scan_idx <= !scan_idx;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      digtal_sw <= scan_idx ? 8'hFD : 8'hFE;
      seg_led   <= seg_code(scan_idx ? tens : ones);
    end
  end

endmodule

// File: tb/tb_counter_ii.sv
// tb/tb_counter_ii.sv - randomized self-checking bench for counter_ii against a behavioural model
module tb_counter_ii;

  localparam int TICK = 4;
  localparam int DB   = 8;
  localparam int SCAN = 5;
  // edges from the DB-th consecutive high raw sample to the run-state change
  localparam int LAT  = 3;
  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] digtal_sw;
  logic [7:0] seg_led;
  logic [7:0] count_out;

  int total = 0;
  int bad   = 0;

  int   m_cnt = 0, m_pre = 0, m_streak = 0, m_pend = 0, m_n = 0;
  logic m_run = 1'b1, m_db = 1'b0;
  logic [7:0] e_sw = 8'hFE, e_seg = 8'hC0;

  counter_ii #(
    .TICK_CYCLES(TICK),
    .DEBOUNCE_CYCLES(DB),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stop(stop),
    .digtal_sw(digtal_sw),
    .seg_led(seg_led),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int idx;
    if (!rst) begin
      m_cnt = 0; m_pre = 0; m_streak = 0; m_pend = 0; m_n = 0;
      m_run = 1'b1; m_db = 1'b0;
      e_sw = 8'hFE; e_seg = 8'hC0;
    end else begin
      idx   = (m_n / SCAN) % 2;
      e_sw  = (idx == 1) ? 8'hFD : 8'hFE;
      e_seg = SEG_TAB[(idx == 1) ? (m_cnt / 10) : (m_cnt % 10)];
      if (m_run) begin
        m_pre++;
        if (m_pre == TICK) begin
          m_pre = 0;
          m_cnt = (m_cnt + 1) % 100;
        end
      end
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) m_run = !m_run;
      end
      if (stop != m_db) begin
        m_streak++;
        if (m_streak == DB) begin
          m_db = stop;
          m_streak = 0;
          if (stop) m_pend = LAT;
        end
      end else begin
        m_streak = 0;
      end
      m_n++;
    end
  endtask

  task automatic step(input logic s);
    stop = s;
    @(posedge clk);
    model_edge();
    #1;
    check("count", count_out, bcd(m_cnt));
    check("digit_sel", digtal_sw, e_sw);
    check("segments", seg_led, e_seg);
    check("bcd_nibbles", (count_out[3:0] <= 4'd9) && (count_out[7:4] <= 4'd9), 1);
  endtask

  task automatic hold(input logic s, input int n);
    repeat (n) step(s);
  endtask

  task automatic bouncy_press();
    hold(1, 1); hold(0, 1); hold(1, 2); hold(0, 1);
    hold(1, 2); hold(0, 1); hold(1, 11); hold(0, 12);
  endtask

  initial begin
    int snap;
    int guard;

    rst = 0;
    hold(0, 3);
    check("rst_count", count_out, 8'h00);
    check("rst_sw", digtal_sw, 8'hFE);
    check("rst_seg", seg_led, 8'hC0);

    rst = 1;
    hold(0, TICK);
    check("first_tick", count_out, 8'h01);
    hold(0, 100 * TICK - TICK);
    check("wrap_to_00", count_out, 8'h00);

    bouncy_press();
    snap = m_cnt;
    hold(0, 5 * TICK);
    check("paused_hold", count_out, bcd(snap));
    bouncy_press();
    hold(0, 3 * TICK);

    for (int i = 0; i < 12; i++) begin
      hold(1, $urandom_range(1, 7));
      hold(0, $urandom_range(9, 14));
    end
    for (int i = 0; i < 60; i++)
      hold(logic'($urandom_range(0, 1)), $urandom_range(1, 20));
    hold(0, 12);
    if (!m_run) begin
      hold(1, 12);
      hold(0, 12);
    end

    guard = 0;
    while (!(m_cnt == 35 && m_pre == 0) && guard < 2000) begin
      step(0);
      guard++;
    end
    check("reach_35_in_budget", guard < 2000, 1);
    hold(1, 12);
    hold(0, 10);
    check("paused_at_37", count_out, 8'h37);

    rst = 0;
    hold(0, 2);
    check("rst_while_paused", count_out, 8'h00);
    check("rst_while_paused_sw", digtal_sw, 8'hFE);
    rst = 1;
    hold(0, TICK - 1);
    check("no_tick_early", count_out, 8'h00);
    hold(0, 1);
    check("resume_after_rst", count_out, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
